// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with blanking gaps and frame-synchronous reload.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLANK_CYC   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd,
  input  logic        load,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame
);

  localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  state_t            state;
  logic [19:0]       shadow;
  logic [19:0]       active;
  logic [1:0]        idx;
  logic [CNT_W-1:0]  cnt;

  // Word that will be on display once the current blank gap ends
  logic [19:0] src;
  logic [3:0]  src_dp;
  assign src    = (idx == 2'd0) ? shadow : active;
  assign src_dp = src[19:16];

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h3F;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] digit_seg(input logic [19:0] w, input logic [1:0] i);
    logic [3:0] nib;
    logic       blank;
    blank = 1'b0;
    case (i)
      2'd0:    nib = w[3:0];
      2'd1:    nib = w[7:4];
      2'd2:    nib = w[11:8];
      default: nib = w[15:12];
    endcase
`ifdef SEG7_LZB_EN
    // Units digit is always shown so a zero value never goes fully dark
    case (i)
      2'd1:    blank = (w[15:4]  == 12'h000);
      2'd2:    blank = (w[15:8]  == 8'h00);
      2'd3:    blank = (w[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    return blank ? 7'h7F : decode(nib);
  endfunction

  // Scan FSM; outputs are registered from the values the next cycle will show
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= BLANK;
      shadow <= '0;
      active <= '0;
      idx    <= '0;
      cnt    <= '0;
      an     <= 4'hF;
      seg    <= 7'h7F;
      dp_n   <= 1'b1;
      frame  <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (load) shadow <= {dp, bcd};
      case (state)
        BLANK: begin
          if (cnt == CNT_W'(BLANK_CYC - 1)) begin
            cnt   <= '0;
            state <= SHOW;
            an    <= ~(4'b0001 << idx);
            seg   <= digit_seg(src, idx);
            dp_n  <= ~src_dp[idx];
            if (idx == 2'd0) begin
              active <= shadow;
              frame  <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        SHOW: begin
          if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
            cnt   <= '0;
            state <= BLANK;
            idx   <= idx + 2'd1;
            an    <= 4'hF;
            seg   <= 7'h7F;
            dp_n  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: expected digits are queued per frame and checked by a monitor.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd;
  logic        load;
  logic [3:0]  dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame;

  int checks;
  int errors;

  logic [11:0] exp_q[$];
  logic [6:0]  seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bcd   (bcd),
    .load  (load),
    .dp    (dp),
    .an    (an),
    .seg   (seg),
    .dp_n  (dp_n),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {an, seg, dp_n} for digit i of word {dp, bcd}
  function automatic logic [11:0] exp_digit(input logic [19:0] w, input int i);
    logic [15:0] v;
    logic [3:0]  nib;
    logic [6:0]  s;
    logic [3:0]  a;
    v   = w[15:0] >> (4 * i);
    nib = v[3:0];
    s   = seg_tbl[nib];
`ifdef SEG7_LZB_EN
    if (i > 0 && v == 16'h0000) s = 7'h7F;
`endif
    a = 4'hF ^ (4'b0001 << i);
    return {a, s, ~w[16 + i]};
  endfunction

  task automatic push_frame(input logic [19:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_digit(w, i));
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame && n < 100);
    if (!frame) chk("frame_timeout", 32'(frame), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    bcd  = b;
    dp   = d;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  // Monitor: checks gap/show lengths, frame alignment and each lit digit against the queue
  logic [3:0]  prev_an;
  int          run;
  bit          first_gap;
  logic [11:0] exp_cur;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_an   <= 4'hF;
      run       <= 0;
      first_gap <= 1'b1;
    end else begin
      chk("frame_align", 32'(frame), 32'(an == 4'hE && prev_an == 4'hF));
      if (an == 4'hF) chk("blank_out", 32'({seg, dp_n}), 32'({7'h7F, 1'b1}));
      if (an != prev_an) begin
        if (prev_an == 4'hF) begin
          if (!first_gap) chk("gap_len", 32'(run), 32'd2);
          first_gap <= 1'b0;
          if (exp_q.size() == 0) begin
            chk("q_empty", 32'(an), 32'hF);
            exp_cur = {an, seg, dp_n};
          end else begin
            exp_cur = exp_q.pop_front();
          end
        end else begin
          chk("show_len", 32'(run), 32'd4);
          chk("show_to_blank", 32'(an), 32'hF);
        end
        run <= 1;
      end else begin
        run <= run + 1;
      end
      if (an != 4'hF) chk("digit", 32'({an, seg, dp_n}), 32'(exp_cur));
      prev_an <= an;
    end
  end

  int n;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    bcd    = '0;
    dp     = '0;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_out", 32'({an, seg, dp_n, frame}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    end

    // Release with a load before the first frame
    rst_n = 1'b1;
    do_load(16'h1234, 4'b0000);
    wait_frame(n);
    chk("first_frame_lat", 32'(n + 1), 32'd2);
    push_frame({4'b0000, 16'h1234});

    // Mid-frame load shows next frame
    repeat (10) @(posedge clk);
    #1;
    do_load(16'h0507, 4'b0000);
    wait_frame(n);
    push_frame({4'b0000, 16'h0507});

    // Load coincident with the frame pulse is deferred one frame
    repeat (23) @(posedge clk);
    #1;
    bcd  = 16'h00A9;
    dp   = 4'b0010;
    load = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    chk("coincident_frame", 32'(frame), 32'd1);
    push_frame({4'b0000, 16'h0507});
    wait_frame(n);
    push_frame({4'b0010, 16'h00A9});

    // Zero and leading-zero patterns
    repeat (10) @(posedge clk);
    #1;
    do_load(16'h0000, 4'b0000);
    wait_frame(n);
    push_frame({4'b0000, 16'h0000});

    repeat (10) @(posedge clk);
    #1;
    do_load(16'h0100, 4'b0000);
    wait_frame(n);
    push_frame({4'b0000, 16'h0100});

    // Reset while digit 2 is lit
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an != 4'b1011 && n < 100);
    chk("reach_digit2", 32'(an), 32'hB);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_out", 32'({an, seg, dp_n, frame}), 32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_frame(n);
    chk("rerelease_lat", 32'(n), 32'd2);
    push_frame({4'b0000, 16'h0000});

    repeat (24) @(posedge clk);
    #1;
    chk("q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
